// File: rtl/e_mul_engine.sv
// Multi-word fixed-point multiplier: schoolbook word-by-word MAC over latched
// operands. The product keeps WORDS words around the binary point.
module e_mul_engine #(
    parameter int WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A       [0:WORDS-1],
    input  logic [15:0] B       [0:WORDS-1],
    output logic        busy,
    output logic        done,
    output logic [15:0] product [0:WORDS-1]
);
    localparam int IW = $clog2(WORDS);
    localparam int PW = $clog2(2 * WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_CARRY = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [15:0]   carry_q, carry_d;
    // a_q/b_q hold the operands little-endian: index 0 is the least significant word
    logic [15:0]   a_q       [0:WORDS-1];
    logic [15:0]   a_d       [0:WORDS-1];
    logic [15:0]   b_q       [0:WORDS-1];
    logic [15:0]   b_d       [0:WORDS-1];
    logic [15:0]   p_q       [0:2*WORDS-1];
    logic [15:0]   p_d       [0:2*WORDS-1];
    logic [15:0]   product_q [0:WORDS-1];
    logic [15:0]   product_d [0:WORDS-1];

    logic [PW-1:0] mac_idx;
    logic [PW-1:0] carry_idx;
    logic [31:0]   mac_t;

    assign mac_idx   = PW'(i_q) + PW'(j_q);
    assign carry_idx = PW'(j_q) + PW'(WORDS);
    // 0xFFFF + 0xFFFF*0xFFFF + 0xFFFF fits exactly in 32 bits
    assign mac_t     = 32'(p_q[mac_idx]) + 32'(a_q[i_q]) * 32'(b_q[j_q]) + 32'(carry_q);

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k < WORDS; k++) begin
                        a_d[k] = A[WORDS-1-k];
                        b_d[k] = B[WORDS-1-k];
                    end
                    for (int k = 0; k < 2 * WORDS; k++) begin
                        p_d[k] = '0;
                    end
                    carry_d = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                p_d[mac_idx] = mac_t[15:0];
                carry_d      = mac_t[31:16];
                if (i_q == IW'(WORDS - 1)) begin
                    state_d = S_CARRY;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_CARRY: begin
                p_d[carry_idx] = carry_q;
                carry_d        = '0;
                i_d            = '0;
                if (j_q == IW'(WORDS - 1)) begin
                    // Only P[WORDS-1..2*WORDS-2] is kept; the top word written here is dropped
                    for (int k = 0; k < WORDS; k++) begin
                        product_d[k] = p_q[2*WORDS-2-k];
                    end
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = S_MAC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            carry_q <= '0;
            for (int k = 0; k < WORDS; k++) begin
                a_q[k]       <= '0;
                b_q[k]       <= '0;
                product_q[k] <= '0;
            end
            for (int k = 0; k < 2 * WORDS; k++) begin
                p_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            p_q       <= p_d;
            product_q <= product_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_product
            assign product[gi] = product_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_e_mul_engine.sv
// Bench for e_mul_engine: one WORDS=2 and one WORDS=32 instance, checked against
// a wide-integer arithmetic reference of the fixed-point product.
module tb_e_mul_engine;
    logic        clk;
    logic        rst2, rst32;
    logic        start2, start32;
    logic        busy2, done2, busy32, done32;
    logic [15:0] a2 [0:1];
    logic [15:0] b2 [0:1];
    logic [15:0] product2 [0:1];
    logic [15:0] a32 [0:31];
    logic [15:0] b32 [0:31];
    logic [15:0] product32 [0:31];

    int checks = 0;
    int errors = 0;

    e_mul_engine #(.WORDS(2)) u_dut2 (
        .clk(clk), .rst(rst2), .start(start2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .product(product2)
    );

    e_mul_engine #(.WORDS(32)) u_dut32 (
        .clk(clk), .rst(rst32), .start(start32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .product(product32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Value of an operand is its packed integer / 2^(16*(w-1)); the product keeps
    // w words around the binary point, truncating below and wrapping above.
    function automatic logic [511:0] ref_mul(input logic [511:0] a, input logic [511:0] b, input int w);
        logic [1023:0] full;
        logic [511:0]  mask;
        full = {512'd0, a} * {512'd0, b};
        full = full >> (16 * (w - 1));
        mask = (w >= 32) ? {512{1'b1}} : ((512'd1 << (16 * w)) - 512'd1);
        return full[511:0] & mask;
    endfunction

    function automatic logic [31:0] pack2();
        return {product2[0], product2[1]};
    endfunction

    function automatic logic [511:0] pack32();
        logic [511:0] v;
        for (int k = 0; k < 32; k++) v[511-16*k -: 16] = product32[k];
        return v;
    endfunction

    task automatic op2(input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] pv, output int lat, output bit ok);
        logic [31:0] held;
        ok = 1'b1;
        @(negedge clk);
        chk("idle_busy2", 512'(busy2), 512'd0);
        a2[0] = av[31:16]; a2[1] = av[15:0];
        b2[0] = bv[31:16]; b2[1] = bv[15:0];
        held   = pack2();
        start2 = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) start2 = 1'b0;
            if (busy2 !== 1'b1) ok = 1'b0;
            if (done2 === 1'b1) begin
                lat = n;
                break;
            end
            if (pack2() !== held) ok = 1'b0;
        end
        pv = pack2();
    endtask

    task automatic op32(input logic [511:0] av, input logic [511:0] bv,
                        output logic [511:0] pv, output int lat, output bit ok);
        logic [511:0] held;
        ok = 1'b1;
        @(negedge clk);
        chk("idle_busy32", 512'(busy32), 512'd0);
        for (int k = 0; k < 32; k++) begin
            a32[k] = av[511-16*k -: 16];
            b32[k] = bv[511-16*k -: 16];
        end
        held    = pack32();
        start32 = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 1200; n++) begin
            @(negedge clk);
            if (n == 1) start32 = 1'b0;
            if (busy32 !== 1'b1) ok = 1'b0;
            if (done32 === 1'b1) begin
                lat = n;
                break;
            end
            if (pack32() !== held) ok = 1'b0;
        end
        pv = pack32();
    endtask

    initial begin
        logic [31:0]  pv2;
        logic [511:0] av, bv, pv, rx, x;
        int           lat, dcount, dedge;
        bit           ok, idle_bad;

        vecs[0] = '{32'h0001_8000, 32'h0001_8000, 32'h0002_4000};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFE_0000};
        vecs[2] = '{32'h0002_0000, 32'h0003_0000, 32'h0006_0000};
        vecs[3] = '{32'h0000_8000, 32'h0000_8000, 32'h0000_4000};
        vecs[4] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        vecs[5] = '{32'h0001_0000, 32'h1234_5678, 32'h1234_5678};
        vecs[6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000};

        rst2 = 1'b1; rst32 = 1'b1; start2 = 1'b0; start32 = 1'b0;
        for (int k = 0; k < 2; k++) begin a2[k] = '0; b2[k] = '0; end
        for (int k = 0; k < 32; k++) begin a32[k] = '0; b32[k] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_busy2", 512'(busy2), 512'd0);
        chk("rst_done2", 512'(done2), 512'd0);
        chk("rst_prod2", 512'(pack2()), 512'd0);
        chk("rst_busy32", 512'(busy32), 512'd0);
        chk("rst_done32", 512'(done32), 512'd0);
        chk("rst_prod32", pack32(), 512'd0);
        rst2 = 1'b0; rst32 = 1'b0;

        // Directed table, WORDS=2
        for (int v = 0; v < 7; v++) begin
            op2(vecs[v].a, vecs[v].b, pv2, lat, ok);
            $display("txn w2 vec%0d A=%h B=%h P=%h lat=%0d", v, vecs[v].a, vecs[v].b, pv2, lat);
            chk($sformatf("vec%0d_prod", v), 512'(pv2), 512'(vecs[v].p));
            chk($sformatf("vec%0d_lat", v), 512'(lat), 512'd7);
            chk($sformatf("vec%0d_busyhold", v), 512'(ok), 512'd1);
        end

        // Random WORDS=2 against the reference model
        for (int r = 0; r < 12; r++) begin
            av = 512'($urandom);
            bv = 512'($urandom);
            op2(av[31:0], bv[31:0], pv2, lat, ok);
            $display("txn w2 rnd%0d A=%h B=%h P=%h lat=%0d", r, av[31:0], bv[31:0], pv2, lat);
            chk($sformatf("rnd%0d_prod", r), 512'(pv2), ref_mul(av, bv, 2));
            chk($sformatf("rnd%0d_lat", r), 512'(lat), 512'd7);
        end

        // Restart while busy / in DONE, operands changed after acceptance
        @(negedge clk);
        a2[0] = 16'h0003; a2[1] = 16'h0000;
        b2[0] = 16'h0002; b2[1] = 16'h8000;
        start2 = 1'b1;
        @(posedge clk);
        dcount = 0; dedge = -1; idle_bad = 1'b0; pv2 = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done2 === 1'b1) begin
                dcount++;
                dedge = n;
                pv2 = pack2();
            end
            if (n >= 8 && busy2 !== 1'b0) idle_bad = 1'b1;
            start2 = (n == 3 || n == 7);
            if (n == 2) begin
                a2[0] = 16'hFFFF; a2[1] = 16'h1234;
                b2[0] = 16'h5555; b2[1] = 16'hAAAA;
            end
        end
        start2 = 1'b0;
        $display("txn w2 restart P=%h dones=%0d edge=%0d", pv2, dcount, dedge);
        chk("restart_dones", 512'(dcount), 512'd1);
        chk("restart_edge", 512'(dedge), 512'd7);
        chk("restart_prod", 512'(pv2), 512'h0007_8000);
        chk("restart_noqueue", 512'(idle_bad), 512'd0);

        // Mid-operation reset
        @(negedge clk);
        a2[0] = 16'h0001; a2[1] = 16'h8000;
        b2[0] = 16'h0001; b2[1] = 16'h8000;
        start2 = 1'b1;
        @(posedge clk);
        dcount = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2 === 1'b1) dcount++;
            rst2 = (n == 4);
        end
        $display("txn w2 abort dones=%0d busy=%0b P=%h", dcount, busy2, pack2());
        chk("abort_dones", 512'(dcount), 512'd0);
        chk("abort_busy", 512'(busy2), 512'd0);
        chk("abort_prod", 512'(pack2()), 512'd0);
        op2(32'h0001_8000, 32'h0001_8000, pv2, lat, ok);
        $display("txn w2 after_abort P=%h lat=%0d", pv2, lat);
        chk("after_abort_prod", 512'(pv2), 512'h0002_4000);
        chk("after_abort_lat", 512'(lat), 512'd7);

        // WORDS=32: identity, zero, random
        for (int k = 0; k < 16; k++) bv[32*k +: 32] = $urandom;
        av = 512'd1 << 496;
        op32(av, bv, pv, lat, ok);
        $display("txn w32 identity lat=%0d", lat);
        chk("w32_ident_prod", pv, bv);
        chk("w32_ident_lat", 512'(lat), 512'd1057);
        chk("w32_ident_busyhold", 512'(ok), 512'd1);
        op32(512'd0, bv, pv, lat, ok);
        $display("txn w32 zero lat=%0d", lat);
        chk("w32_zero_prod", pv, 512'd0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 16; k++) begin
                av[32*k +: 32] = $urandom;
                bv[32*k +: 32] = $urandom;
            end
            av[511:496] = 16'(r + 1);
            op32(av, bv, pv, lat, ok);
            $display("txn w32 rnd%0d lat=%0d", r, lat);
            chk($sformatf("w32_rnd%0d_prod", r), pv, ref_mul(av, bv, 32));
        end

        // Chained squaring of 1 + 2^-15, result fed straight back
        x  = (512'd1 << 496) | (512'd2 << 480);
        rx = x;
        for (int it = 1; it <= 15; it++) begin
            op32(x, x, pv, lat, ok);
            rx = ref_mul(rx, rx, 32);
            $display("txn w32 square%0d int=%h lat=%0d", it, pv[511:496], lat);
            chk($sformatf("sq%0d_prod", it), pv, rx);
            chk($sformatf("sq%0d_lat", it), 512'(lat), 512'd1057);
            x = pv;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/e_mul_engine.md
E_MUL_ENGINE -- requirements
Module: e_mul_engine

Interface
REQ-001 Parameter: WORDS, default 32, number of 16-bit words per operand and result (legal range 2..64).
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: A  input  16 x [0:WORDS-1]  multiplicand, fixed point (see REQ-007).
REQ-006 Port: B  input  16 x [0:WORDS-1]  multiplier, same format as A.
REQ-007 Format: word 0 = integer part (MSW); words 1..WORDS-1 = fraction, descending weight; value = sum X[k]*2^(-16k).
REQ-008 Port: busy  output  1  high from the cycle after start acceptance until DONE is left.
REQ-009 Port: done  output  1  single-cycle pulse, product valid.
REQ-010 Port: product  output  16 x [0:WORDS-1]  registered result, same format as A/B.

Function
REQ-011 SHALL implement states IDLE, MAC, CARRY, DONE; the reset state is IDLE.
REQ-012 IDLE: start=1 -> latch A and B internally, clear the 2*WORDS-word accumulator P, carry=0, i=0, j=0, go to MAC; start=0 -> stay.
REQ-013 Operands SHALL be taken only from the latched copies; A/B changes after acceptance have no effect.
REQ-014 Internal indexing little-endian: a_i = A[WORDS-1-i], b_j = B[WORDS-1-j], P[l] weight 2^(16l).
REQ-015 MAC: t = P[i+j] + a_i*b_j + carry (32-bit, cannot overflow); P[i+j] <= t[15:0]; carry <= t[31:16]; i==WORDS-1 -> CARRY, else i++.
REQ-016 CARRY: P[j+WORDS] <= carry; carry <= 0; i <= 0; j==WORDS-1 -> load product and go to DONE, else j++ and go to MAC.
REQ-017 Result: product[k] = P[2*WORDS-2-k] for k=0..WORDS-1, i.e. floor(A*B) truncated to WORDS*16 bits; fraction bits below word WORDS-1 discarded (no rounding); integer overflow above 16 bits (P[2*WORDS-1] and integer carries) silently dropped, no flag.
REQ-018 DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-019 Latency: with the start-sampling edge as edge 0, done SHALL be high at edge WORDS*(WORDS+1)+1 (7 for WORDS=2, 1057 for WORDS=32).
REQ-020 product SHALL be valid in the same cycle done=1 and held unchanged until the next DONE load; no intermediate values ever visible.
REQ-021 start while busy or in DONE SHALL be ignored (not queued); the next accepted start is the first one sampled in IDLE.
REQ-022 busy=1 in MAC, CARRY, DONE; busy=0 in IDLE.
REQ-023 Caller contract: a requester may assert start the cycle after it sees done; the engine is in IDLE then and SHALL accept it.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, done=0, busy=0, product all words 0x0000, P=0, carry=0, i=j=0, regardless of state.
REQ-025 rst asserted mid-operation SHALL abort the operation with no done pulse; the next start after rst deassertion SHALL run a full, correct operation.
REQ-026 rst has priority over start in the same cycle.

Verification
REQ-027 WORDS=2, A=B={0x0001,0x8000} (1.5), start 1 cycle -> done at edge 7, product={0x0002,0x4000}, busy high edges 1..7.
REQ-028 WORDS=2, A=B={0xFFFF,0xFFFF} -> product={0xFFFE,0x0000} (max-carry path, overflow dropped).
REQ-029 WORDS=32, A={0x0001,0,...,0}, B random -> product==B, done at edge 1057; A=0 -> product all 0.
REQ-030 WORDS=2, start re-pulsed at edges 3 and in the DONE cycle, A/B changed while busy -> exactly one done, result from original operands.
REQ-031 WORDS=2, rst pulsed at edge 4 of an operation -> no done, product=0, busy=0; new start -> correct result at edge 7 after it.
REQ-032 Chained squaring: requester feeds product back as A=B on each done, 15 iterations from {0x0001,0x0000}+2^-15 fraction, WORDS=32 -> each result matches a bit-exact reference model; no lost or duplicate done pulses.
